collision_detector: RTL

- Upstream neighbour of the player physics stage; produces the 32-bit `wall` contact vector it consumes.
- Each scan samples the player position and controller word, then walks the stage block table one block per cycle, accumulating contact flags. Results are committed atomically.
- One instance per player; scans run back-to-back continuously.

---
 rtl/collision_pkg.sv | 36 +++
 rtl/stage_rom.sv | 20 ++
 rtl/collision_detector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the player collision detector.
package collision_pkg;

   localparam int unsigned COORD_W = 16;
   localparam int unsigned EXT_W   = 17;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned FLAG_W  = 5;
   localparam int unsigned WALL_W  = 32;

   localparam int unsigned WALL_UP    = 0;
   localparam int unsigned WALL_DOWN  = 1;
   localparam int unsigned WALL_RIGHT = 2;
   localparam int unsigned WALL_LEFT  = 3;
   localparam int unsigned WALL_PLAT  = 4;

   typedef struct packed {
      logic [COORD_W-1:0] x_min;
      logic [COORD_W-1:0] x_max;
      logic [COORD_W-1:0] y_min;
      logic [COORD_W-1:0] y_max;
      logic               solid;
   } block_t;

   typedef enum logic [1:0] {
      ST_SAMPLE = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Unsigned subtraction that clamps at zero instead of wrapping.
   function automatic logic [EXT_W-1:0] sat_sub(input logic [EXT_W-1:0] a,
                                                input logic [EXT_W-1:0] b);
      return (a > b) ? EXT_W'(a - b) : '0;
   endfunction

endpackage

// File: rtl/stage_rom.sv
// Stage block table; combinational read by index, empty block beyond the table.
module stage_rom
   import collision_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output block_t           blk_o
);

   always_comb begin
      blk_o = '0;
      case (idx_i)
         4'd0: blk_o = '{x_min: 16'd40,  x_max: 16'd600, y_min: 16'd40,  y_max: 16'd60,  solid: 1'b1};
         4'd1: blk_o = '{x_min: 16'd100, x_max: 16'd200, y_min: 16'd150, y_max: 16'd155, solid: 1'b0};
         4'd2: blk_o = '{x_min: 16'd600, x_max: 16'd620, y_min: 16'd60,  y_max: 16'd400, solid: 1'b1};
         4'd3: blk_o = '{x_min: 16'd250, x_max: 16'd350, y_min: 16'd300, y_max: 16'd320, solid: 1'b1};
         default: blk_o = '0;
      endcase
   end

endmodule

// File: rtl/collision_detector.sv
// Scans the stage block table once per NUM_BLOCKS+2 cycles and publishes contact flags.
// Optional macro COLLISION_SCREEN_EDGE_EN makes the screen border (except the floor) solid.
module collision_detector
   import collision_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 4,
   parameter int unsigned PLAYER_W   = 16,
   parameter int unsigned PLAYER_H   = 32,
   parameter int unsigned MARGIN     = 2,
   parameter int unsigned SCREEN_W   = 640,
   parameter int unsigned SCREEN_H   = 480
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WALL_W-1:0] position,
   input  logic [WALL_W-1:0] controller_in,
   output logic [WALL_W-1:0] wall,
   output logic              wall_valid,
   output logic              scan_busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
   localparam logic [EXT_W-1:0] PW = EXT_W'(PLAYER_W);
   localparam logic [EXT_W-1:0] PH = EXT_W'(PLAYER_H);
   localparam logic [EXT_W-1:0] MG = EXT_W'(MARGIN);

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [COORD_W-1:0]  px_q;
   logic [COORD_W-1:0]  py_q;
   logic                drop_q;
   logic [FLAG_W-1:0]   acc_q;
   logic [FLAG_W-1:0]   wall_q;
   logic                wall_valid_q;
   logic                scan_busy_q;

   block_t              blk;
   logic [FLAG_W-1:0]   flags_c;
   logic [FLAG_W-1:0]   edge_c;

   stage_rom u_rom (
      .idx_i (idx_q),
      .blk_o (blk)
   );

   logic [EXT_W-1:0] px_e, py_e, pxw_e, pyh_e;
   logic [EXT_W-1:0] xmin_e, xmax_e, ymin_e, ymax_e;
   logic             xov, yov;

   // Contact flags contributed by the block currently addressed.
   always_comb begin
      px_e    = {1'b0, px_q};
      py_e    = {1'b0, py_q};
      pxw_e   = px_e + PW;
      pyh_e   = py_e + PH;
      xmin_e  = {1'b0, blk.x_min};
      xmax_e  = {1'b0, blk.x_max};
      ymin_e  = {1'b0, blk.y_min};
      ymax_e  = {1'b0, blk.y_max};
      xov     = (px_e < xmax_e) && (pxw_e > xmin_e);
      yov     = (py_e < ymax_e) && (pyh_e > ymin_e);
      flags_c = '0;
      if (xov && (py_e >= ymax_e) && (py_e <= ymax_e + MG)) begin
         if (blk.solid)   flags_c[WALL_DOWN] = 1'b1;
         else if (!drop_q) flags_c[WALL_PLAT] = 1'b1;
      end
      if (blk.solid && xov && (pyh_e >= sat_sub(ymin_e, MG)) && (pyh_e <= ymin_e))
         flags_c[WALL_UP] = 1'b1;
      if (blk.solid && yov && (pxw_e >= sat_sub(xmin_e, MG)) && (pxw_e <= xmin_e))
         flags_c[WALL_RIGHT] = 1'b1;
      if (blk.solid && yov && (px_e >= xmax_e) && (px_e <= xmax_e + MG))
         flags_c[WALL_LEFT] = 1'b1;
   end

`ifdef COLLISION_SCREEN_EDGE_EN
   // Screen border acts as solid walls on left, right and top only.
   always_comb begin
      edge_c = '0;
      if ({1'b0, px_q} <= MG)
         edge_c[WALL_LEFT] = 1'b1;
      if (({1'b0, px_q} + PW) >= sat_sub(EXT_W'(SCREEN_W), MG))
         edge_c[WALL_RIGHT] = 1'b1;
      if (({1'b0, py_q} + PH) >= sat_sub(EXT_W'(SCREEN_H), MG))
         edge_c[WALL_UP] = 1'b1;
   end
`else
   assign edge_c = '0;
   logic unused_screen;
   assign unused_screen = ^{32'(SCREEN_W), 32'(SCREEN_H)};
`endif

   logic unused_ctrl;
   assign unused_ctrl = ^{controller_in[31:8], controller_in[3:0]};

   // Scan sequencer: SAMPLE -> SCAN x NUM_BLOCKS -> COMMIT.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_SAMPLE;
         idx_q        <= '0;
         px_q         <= '0;
         py_q         <= '0;
         drop_q       <= 1'b0;
         acc_q        <= '0;
         wall_q       <= '0;
         wall_valid_q <= 1'b0;
         scan_busy_q  <= 1'b0;
      end else begin
         wall_valid_q <= 1'b0;
         case (state_q)
            ST_SAMPLE: begin
               px_q        <= position[31:16];
               py_q        <= position[15:0];
               drop_q      <= (controller_in[7:4] == 4'd0);
               acc_q       <= '0;
               idx_q       <= '0;
               scan_busy_q <= 1'b1;
               state_q     <= ST_SCAN;
            end
            ST_SCAN: begin
               acc_q <= acc_q | flags_c;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  scan_busy_q <= 1'b0;
                  state_q     <= ST_COMMIT;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            ST_COMMIT: begin
               wall_q       <= acc_q | edge_c;
               wall_valid_q <= 1'b1;
               state_q      <= ST_SAMPLE;
            end
            default: begin
               scan_busy_q <= 1'b0;
               state_q     <= ST_SAMPLE;
            end
         endcase
      end
   end

   assign wall       = WALL_W'(wall_q);
   assign wall_valid = wall_valid_q;
   assign scan_busy  = scan_busy_q;

endmodule
